q2_panel_seq: RTL and testbench

Front-panel sequencer for the Q2 datapath. Turns raw operator button presses (examine, examine-next, deposit, deposit-next, run, stop, step) into the timed level and strobe sequences that the `q2_slice` array consumes: `sw`, `dep`, `wrp`, the P-increment strobe, and memory read/write. It also gates CPU execution through a `run` level that drops only at instruction boundaries. It sits between the panel switch board and the slice array and memory control, and it is the initiator of every panel-side slice operation.

---
 rtl/q2_panel_seq.sv | 215 +++++++++++++++++++++
 tb/tb_q2_panel_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_panel_seq.sv
`default_nettype none
// ============================================================================
// Module   : q2_panel_seq
// Brief    : Front-panel sequencer that turns operator button presses into
//            timed level/strobe phases for the slice array and memory.
// Revision : 1.0 - initial release
// ============================================================================
module q2_panel_seq #(
    parameter int STROBE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_exam,
    input  logic btn_exam_next,
    input  logic btn_dep,
    input  logic btn_dep_next,
    input  logic btn_run,
    input  logic btn_stop,
    input  logic btn_step,
    input  logic cpu_done,
    output logic sw,
    output logic dep,
    output logic wrp,
    output logic incp,
    output logic mem_rd,
    output logic mem_wr,
    output logic run,
    output logic busy
);

    localparam int B_EXAM      = 0;
    localparam int B_EXAM_NEXT = 1;
    localparam int B_DEP       = 2;
    localparam int B_DEP_NEXT  = 3;
    localparam int B_RUN       = 4;
    localparam int B_STOP      = 5;
    localparam int B_STEP      = 6;

    localparam logic [4:0] C_STB_LAST = 5'(STROBE);
    localparam logic [4:0] C_HOLD     = 5'(STROBE + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_P_LOAD  = 3'd1,
        S_P_INC   = 3'd2,
        S_M_READ  = 3'd3,
        S_M_WRITE = 3'd4,
        S_RUN     = 3'd5,
        S_STEP    = 3'd6
    } state_t;

    // Phase that follows the current one when its hold cycle ends.
    typedef enum logic [1:0] {
        F_NONE  = 2'd0,
        F_READ  = 2'd1,
        F_WRITE = 2'd2
    } follow_t;

    state_t      state_q, state_d;
    follow_t     follow_q, follow_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        stop_pend_q, stop_pend_d;
    logic [6:0]  sync1_q, sync1_d;
    logic [6:0]  sync2_q, sync2_d;
    logic [6:0]  sync3_q, sync3_d;
    logic [6:0]  press;

    logic sw_q, sw_d;
    logic dep_q, dep_d;
    logic wrp_q, wrp_d;
    logic incp_q, incp_d;
    logic mem_rd_q, mem_rd_d;
    logic mem_wr_q, mem_wr_d;
    logic run_q, run_d;
    logic busy_q, busy_d;
    logic strobe_on;

    always_comb begin
        sync1_d = {btn_step, btn_stop, btn_run, btn_dep_next,
                   btn_dep, btn_exam_next, btn_exam};
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        press   = sync2_q & ~sync3_q;
    end

    always_comb begin
        state_d     = state_q;
        follow_d    = follow_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d       = 5'd0;
                follow_d    = F_NONE;
                stop_pend_d = 1'b0;
                if (press[B_STEP]) begin
                    state_d = S_STEP;
                end else if (press[B_RUN]) begin
                    state_d = S_RUN;
                end else if (press[B_DEP_NEXT]) begin
                    state_d  = S_P_INC;
                    follow_d = F_WRITE;
                end else if (press[B_DEP]) begin
                    state_d = S_M_WRITE;
                end else if (press[B_EXAM_NEXT]) begin
                    state_d  = S_P_INC;
                    follow_d = F_READ;
                end else if (press[B_EXAM]) begin
                    state_d  = S_P_LOAD;
                    follow_d = F_READ;
                end
            end

            S_P_LOAD, S_P_INC, S_M_READ, S_M_WRITE: begin
                if (cnt_q == C_HOLD) begin
                    cnt_d    = 5'd0;
                    follow_d = F_NONE;
                    case (follow_q)
                        F_READ:  state_d = S_M_READ;
                        F_WRITE: state_d = S_M_WRITE;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_RUN: begin
                if (press[B_STOP]) begin
                    stop_pend_d = 1'b1;
                end
                if (cpu_done && (stop_pend_q || press[B_STOP])) begin
                    state_d     = S_IDLE;
                    stop_pend_d = 1'b0;
                end
            end

            // cnt_q is zero only in the entry cycle, where cpu_done is ignored.
            S_STEP: begin
                cnt_d = 5'd1;
                if (cpu_done && (cnt_q != 5'd0)) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = 5'd0;
                follow_d = F_NONE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that they register together.
    always_comb begin
        strobe_on = (cnt_d != 5'd0) && (cnt_d <= C_STB_LAST);
        sw_d      = (state_d == S_P_LOAD) || (state_d == S_M_WRITE);
        dep_d     = (state_d == S_M_WRITE);
        wrp_d     = (state_d == S_P_LOAD)  && strobe_on;
        incp_d    = (state_d == S_P_INC)   && strobe_on;
        mem_rd_d  = (state_d == S_M_READ)  && strobe_on;
        mem_wr_d  = (state_d == S_M_WRITE) && strobe_on;
        run_d     = (state_d == S_RUN) || (state_d == S_STEP);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            follow_q    <= F_NONE;
            cnt_q       <= 5'd0;
            stop_pend_q <= 1'b0;
            sync1_q     <= 7'd0;
            sync2_q     <= 7'd0;
            sync3_q     <= 7'd0;
            sw_q        <= 1'b0;
            dep_q       <= 1'b0;
            wrp_q       <= 1'b0;
            incp_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            follow_q    <= follow_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            sw_q        <= sw_d;
            dep_q       <= dep_d;
            wrp_q       <= wrp_d;
            incp_q      <= incp_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
        end
    end

    assign sw     = sw_q;
    assign dep    = dep_q;
    assign wrp    = wrp_q;
    assign incp   = incp_q;
    assign mem_rd = mem_rd_q;
    assign mem_wr = mem_wr_q;
    assign run    = run_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_q2_panel_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_q2_panel_seq
// Brief    : Self-checking bench for q2_panel_seq (vector table, directed
//            sequences, randomized traffic against a phase-queue model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_q2_panel_seq;

    localparam int S = 2;
    localparam int P = S + 2;

    // Output pattern bits: {sw, dep, wrp, incp, mem_rd, mem_wr, run, busy}
    localparam logic [7:0] O_SW   = 8'h80;
    localparam logic [7:0] O_DEP  = 8'h40;
    localparam logic [7:0] O_WRP  = 8'h20;
    localparam logic [7:0] O_INCP = 8'h10;
    localparam logic [7:0] O_RD   = 8'h08;
    localparam logic [7:0] O_WR   = 8'h04;
    localparam logic [7:0] O_RUN  = 8'h02;
    localparam logic [7:0] O_BUSY = 8'h01;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [6:0] btns     = 7'd0;
    logic       cpu_done = 1'b0;
    logic sw, dep, wrp, incp, mem_rd, mem_wr, run, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    q2_panel_seq #(.STROBE(S)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_exam      (btns[0]),
        .btn_exam_next (btns[1]),
        .btn_dep       (btns[2]),
        .btn_dep_next  (btns[3]),
        .btn_run       (btns[4]),
        .btn_stop      (btns[5]),
        .btn_step      (btns[6]),
        .cpu_done      (cpu_done),
        .sw            (sw),
        .dep           (dep),
        .wrp           (wrp),
        .incp          (incp),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .run           (run),
        .busy          (busy)
    );

    wire [7:0] dut_vec = {sw, dep, wrp, incp, mem_rd, mem_wr, run, busy};

    // ---------------- reference model: queue of per-cycle output patterns
    logic [7:0] q[$];
    logic [7:0] model_out = 8'h00;
    logic [6:0] h1 = 7'd0, h2 = 7'd0, h3 = 7'd0;   // button samples, newest first
    int         mode = 0;                          // 0 idle, 1 phases, 2 run, 3 step
    bit         pend = 1'b0;
    bit         first = 1'b0;

    task automatic push_phase(input logic [7:0] lv, input logic [7:0] stb);
        q.push_back(lv | O_BUSY);
        for (int i = 0; i < S; i++) q.push_back(lv | stb | O_BUSY);
        q.push_back(lv | O_BUSY);
    endtask

    task automatic model_reset();
        q.delete();
        model_out = 8'h00;
        h1 = 7'd0; h2 = 7'd0; h3 = 7'd0;
        mode = 0; pend = 1'b0; first = 1'b0;
    endtask

    task automatic model_step();
        logic [6:0] p;
        p  = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = btns;
        case (mode)
            1: begin
                if (q.size() > 0) model_out = q.pop_front();
                else begin model_out = 8'h00; mode = 0; end
            end
            2: begin
                if (p[5]) pend = 1'b1;
                if (cpu_done && pend) begin model_out = 8'h00; mode = 0; end
            end
            3: begin
                if (cpu_done && !first) begin model_out = 8'h00; mode = 0; end
                first = 1'b0;
            end
            default: begin
                if (p[6]) begin
                    mode = 3; first = 1'b1; model_out = O_RUN | O_BUSY;
                end else if (p[4]) begin
                    mode = 2; pend = 1'b0; model_out = O_RUN | O_BUSY;
                end else begin
                    if (p[3]) begin
                        push_phase(8'h00, O_INCP); push_phase(O_SW | O_DEP, O_WR);
                    end else if (p[2]) begin
                        push_phase(O_SW | O_DEP, O_WR);
                    end else if (p[1]) begin
                        push_phase(8'h00, O_INCP); push_phase(8'h00, O_RD);
                    end else if (p[0]) begin
                        push_phase(O_SW, O_WRP); push_phase(8'h00, O_RD);
                    end
                    if (q.size() > 0) begin model_out = q.pop_front(); mode = 1; end
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every cycle the DUT must match the model exactly.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_out) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual=%b required=%b", $time, dut_vec, model_out);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic press(input logic [6:0] b);
        @(negedge clk); btns = b;
        @(negedge clk); btns = 7'd0;
    endtask

    task automatic wait_run_high(input string name);
        int k = 0;
        while (run !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk(name, int'(run), 1);
    endtask

    // ---------------- vector table
    typedef struct {
        logic [6:0] btn;
        logic [6:0] mid;
        int busy_n, sw_n, dep_n, wrp_n, incp_n, rd_n, wr_n;
    } vec_t;

    vec_t tbl[6];

    task automatic run_vector(input int idx);
        int nb = 0, nsw = 0, nd = 0, nwp = 0, ni = 0, nr = 0, nw = 0, first_busy = -1, overlap = 0;
        @(negedge clk); btns = tbl[idx].btn;
        for (int i = 1; i <= 3 * P + 8; i++) begin
            @(negedge clk);
            if (i == 1) btns = 7'd0;
            if (i == 2) btns = tbl[idx].mid;
            if (i == 3) btns = 7'd0;
            nb  += busy   ? 1 : 0;
            nsw += sw     ? 1 : 0;
            nd  += dep    ? 1 : 0;
            nwp += wrp    ? 1 : 0;
            ni  += incp   ? 1 : 0;
            nr  += mem_rd ? 1 : 0;
            nw  += mem_wr ? 1 : 0;
            if ((32'(wrp) + 32'(incp) + 32'(mem_rd) + 32'(mem_wr)) > 1) overlap++;
            if (busy && first_busy < 0) first_busy = i;
        end
        chk($sformatf("v%0d_latency", idx), first_busy, 3);
        chk($sformatf("v%0d_busy", idx), nb, tbl[idx].busy_n);
        chk($sformatf("v%0d_sw", idx), nsw, tbl[idx].sw_n);
        chk($sformatf("v%0d_dep", idx), nd, tbl[idx].dep_n);
        chk($sformatf("v%0d_wrp", idx), nwp, tbl[idx].wrp_n);
        chk($sformatf("v%0d_incp", idx), ni, tbl[idx].incp_n);
        chk($sformatf("v%0d_rd", idx), nr, tbl[idx].rd_n);
        chk($sformatf("v%0d_wr", idx), nw, tbl[idx].wr_n);
        chk($sformatf("v%0d_overlap", idx), overlap, 0);
    endtask

    initial begin
        int nb, nwp, nr, k;
        //             btn     mid     busy  sw  dep wrp incp rd wr
        tbl[0] = '{7'h01, 7'h08, 2 * P, P, 0, S, 0, S, 0};   // exam
        tbl[1] = '{7'h02, 7'h40, 2 * P, 0, 0, 0, S, S, 0};   // exam_next
        tbl[2] = '{7'h04, 7'h01, P,     P, P, 0, 0, 0, S};   // dep
        tbl[3] = '{7'h08, 7'h10, 2 * P, P, P, 0, S, 0, S};   // dep_next
        tbl[4] = '{7'h05, 7'h01, P,     P, P, 0, 0, 0, S};   // dep + exam together
        tbl[5] = '{7'h0A, 7'h00, 2 * P, P, P, 0, S, 0, S};   // dep_next beats exam_next

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(dut_vec), 0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", int'(dut_vec), 0);

        for (int i = 0; i < 6; i++) begin
            run_vector(i);
            repeat (4) @(negedge clk);
        end

        // run, three instructions, then stop with cpu_done five cycles later
        press(7'h10);
        wait_run_high("run_enter");
        for (int i = 0; i < 3; i++) begin
            repeat (2) @(negedge clk);
            cpu_done = 1'b1;
            @(negedge clk); cpu_done = 1'b0;
            @(negedge clk);
            chk($sformatf("run_hold%0d", i), int'(run), 1);
        end
        @(negedge clk); btns[5] = 1'b1;
        @(negedge clk); btns[5] = 1'b0;
        repeat (4) @(negedge clk);
        chk("run_before_done", int'(run), 1);
        cpu_done = 1'b1;
        @(negedge clk); cpu_done = 1'b0;
        chk("run_after_stop", int'(run), 0);
        chk("busy_after_stop", int'(busy), 0);

        // stop press and cpu_done land on the same edge
        repeat (3) @(negedge clk);
        press(7'h10);
        wait_run_high("run_enter2");
        @(negedge clk); btns[5] = 1'b1;
        @(negedge clk); btns[5] = 1'b0;
        @(negedge clk);
        chk("run_before_same", int'(run), 1);
        cpu_done = 1'b1;
        @(negedge clk); cpu_done = 1'b0;
        chk("run_after_same", int'(run), 0);
        chk("busy_after_same", int'(busy), 0);

        // step: cpu_done in the entry cycle is ignored
        repeat (3) @(negedge clk);
        @(negedge clk); btns[6] = 1'b1;
        @(negedge clk); btns[6] = 1'b0;
        @(negedge clk);
        chk("step_not_yet", int'(run), 0);
        @(negedge clk);
        chk("step_enter", int'(run), 1);
        cpu_done = 1'b1;
        @(negedge clk); cpu_done = 1'b0;
        chk("step_entry_done_ignored", int'(run), 1);
        repeat (2) @(negedge clk);
        cpu_done = 1'b1;
        @(negedge clk); cpu_done = 1'b0;
        chk("step_exit_run", int'(run), 0);
        chk("step_exit_busy", int'(busy), 0);

        // asynchronous reset in the middle of a memory write strobe
        repeat (3) @(negedge clk);
        press(7'h04);
        k = 0;
        while (mem_wr !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("mem_wr_seen", int'(mem_wr), 1);
        #2 rst_n = 1'b0; btns[0] = 1'b1;
        #1 chk("async_reset_drop", int'({sw, dep, mem_wr, busy}), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nb = 0; nwp = 0; nr = 0;
        for (int i = 0; i < 4 * P + 6; i++) begin
            @(negedge clk);
            nb  += busy   ? 1 : 0;
            nwp += wrp    ? 1 : 0;
            nr  += mem_rd ? 1 : 0;
        end
        chk("held_exam_busy", nb, 2 * P);
        chk("held_exam_wrp", nwp, S);
        chk("held_exam_rd", nr, S);
        btns = 7'd0;

        // randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            btns = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'd0;
            if ($urandom_range(0, 9) == 0) btns[5] = 1'b1;
            cpu_done = !cpu_done && ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        btns = 7'd0; cpu_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
